// File: rtl/sigcapture.sv
// rtl/sigcapture.sv - triggered sample recorder with in-order playback; option macro SIGCAPTURE_PRETRIG_EN
module sigcapture #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               arm,
  input  logic [D_WIDTH-1:0] threshold,
  input  logic [A_WIDTH-1:0] post_len,
  input  logic [D_WIDTH-1:0] mic_signal,
  input  logic               rd_req,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] A_ONE   = 1;
  localparam logic [A_WIDTH:0]   LEN_ONE = 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t             state, state_nxt;
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr, rd_ptr, cnt, plen_q;
  logic [A_WIDTH:0]   rd_left;
  logic               trig, wr_en, cap_wr, cap_end, rd_fire, go_armed;
  logic [A_WIDTH-1:0] rd_start;
  logic [A_WIDTH:0]   rd_len;
`ifdef SIGCAPTURE_PRETRIG_EN
  logic [A_WIDTH-1:0] trig_addr;
`endif

  // Event strobes and next-state decode; DONE only reads when arm is not aborting it
  always_comb begin
    state_nxt = state;
    trig      = (state == ARMED) && en && (mic_signal >= threshold);
    cap_wr    = (state == CAPTURE) && en && (cnt != '0);
    cap_end   = (state == CAPTURE) && en && (cnt == '0);
    rd_fire   = (state == DONE) && rd_req && !arm;
    go_armed  = arm && ((state == IDLE) || (state == DONE));
`ifdef SIGCAPTURE_PRETRIG_EN
    wr_en     = ((state == ARMED) && en) || cap_wr;
    rd_start  = trig_addr + plen_q + A_ONE;
    rd_len    = {1'b1, {A_WIDTH{1'b0}}};
`else
    wr_en     = trig || cap_wr;
    rd_start  = '0;
    rd_len    = {1'b0, plen_q} + LEN_ONE;
`endif
    case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   if (trig) state_nxt = CAPTURE;
      CAPTURE: if (cap_end) state_nxt = DONE;
      DONE: begin
        if (arm) state_nxt = ARMED;
        else if (rd_fire && rd_left == LEN_ONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy/done decoded from next state so they follow the cause by one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
      done  <= (state_nxt == DONE);
    end
  end

  // Pointers, counters and the registered playback output
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      plen_q   <= '0;
      rd_left  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef SIGCAPTURE_PRETRIG_EN
      trig_addr <= '0;
`endif
    end else begin
      rd_valid <= rd_fire;
      if (go_armed) wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + A_ONE;
      if (trig) begin
        cnt    <= post_len;
        plen_q <= post_len;
`ifdef SIGCAPTURE_PRETRIG_EN
        trig_addr <= wr_ptr;
`endif
      end else if (cap_wr) begin
        cnt <= cnt - A_ONE;
      end
      if (cap_end) begin
        rd_ptr  <= rd_start;
        rd_left <= rd_len;
      end else if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + A_ONE;
        rd_left <= rd_left - LEN_ONE;
      end
    end
  end

  // Sample buffer; contents survive reset and re-arm
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= mic_signal;
  end

endmodule

// File: tb/tb_sigcapture.sv
// tb/tb_sigcapture.sv - directed self-checking bench for sigcapture
module tb_sigcapture;
`ifdef SIGCAPTURE_PRETRIG_EN
  localparam int AW = 4;
`else
  localparam int AW = 9;
`endif
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, en, arm, rd_req;
  logic [DW-1:0] threshold, mic_signal, rd_data;
  logic [AW-1:0] post_len;
  logic          rd_valid, busy, done;
  int            checks = 0;
  int            passed = 0;

  sigcapture #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .arm(arm), .threshold(threshold),
    .post_len(post_len), .mic_signal(mic_signal), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DW-1:0] v);
    en = 1'b1; mic_signal = v; tick(); en = 1'b0;
  endtask

  task automatic do_arm;
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; tick(); tick();
    checks++;
    if ({rd_data, rd_valid, busy, done} !== '0)
      $display("FAIL reset_outs: got data=%0d v=%b b=%b d=%b want all 0", rd_data, rd_valid, busy, done);
    else passed++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; tick();
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_rdreq%0d: got v=%b b=%b d=%b want 0 0 0", i, rd_valid, busy, done);
      else passed++;
    end
    rd_req = 1'b0;
  endtask

  task automatic test_basic;
    logic [DW-1:0] inp [7] = '{10, 50, 120, 7, 8, 9, 200};
    logic [DW-1:0] exp_d [4] = '{120, 7, 8, 9};
    threshold = 8'd100; post_len = 3;
    do_arm();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_armed: got b=%b d=%b want 1 0", busy, done);
    else passed++;
    foreach (inp[i]) feed(inp[i]);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) $display("FAIL basic_done: got b=%b d=%b want 0 1", busy, done);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      logic exp_done;
      exp_done = (i < 3);
      rd_req = 1'b1; tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d[i] || done !== exp_done)
        $display("FAIL basic_read%0d: got v=%b data=%0d d=%b want 1 %0d %b", i, rd_valid, rd_data, done, exp_d[i], exp_done);
      else passed++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0 || done !== 1'b0)
        $display("FAIL basic_extra%0d: got v=%b d=%b want 0 0", i, rd_valid, done);
      else passed++;
    end
    rd_req = 1'b0;
  endtask

  task automatic test_post_zero;
    threshold = 8'd0; post_len = 0;
    do_arm();
    feed(8'd55);
    feed(8'd66);
    checks++;
    if (done !== 1'b1) $display("FAIL post0_done: got d=%b want 1", done);
    else passed++;
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd55 || done !== 1'b0)
      $display("FAIL post0_read: got v=%b data=%0d d=%b want 1 55 0", rd_valid, rd_data, done);
    else passed++;
    tick();
    checks++;
    if (rd_valid !== 1'b0) $display("FAIL post0_pulse: got v=%b want 0", rd_valid);
    else passed++;
  endtask

  task automatic test_abort;
    logic [DW-1:0] inp [5] = '{120, 1, 2, 3, 4};
    logic [DW-1:0] inp2 [5] = '{150, 5, 6, 7, 8};
    logic [DW-1:0] exp_d [4] = '{150, 5, 6, 7};
    threshold = 8'd100; post_len = 3;
    do_arm();
    foreach (inp[i]) feed(inp[i]);
    for (int i = 0; i < 2; i++) begin
      rd_req = 1'b1; tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== inp[i])
        $display("FAIL abort_pre%0d: got v=%b data=%0d want 1 %0d", i, rd_valid, rd_data, inp[i]);
      else passed++;
    end
    arm = 1'b1; rd_req = 1'b1; tick(); arm = 1'b0; rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL abort_arm: got v=%b b=%b d=%b want 0 1 0", rd_valid, busy, done);
    else passed++;
    foreach (inp2[i]) feed(inp2[i]);
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d[i])
        $display("FAIL abort_re%0d: got v=%b data=%0d want 1 %0d", i, rd_valid, rd_data, exp_d[i]);
      else passed++;
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] inp [5] = '{130, 11, 12, 13, 14};
    threshold = 8'd100; post_len = 3;
    do_arm();
    feed(8'd120);
    feed(8'd1);
    rst = 1'b0; tick(); rst = 1'b1;
    checks++;
    if ({rd_data, rd_valid, busy, done} !== '0)
      $display("FAIL midrst_outs: got data=%0d v=%b b=%b d=%b want all 0", rd_data, rd_valid, busy, done);
    else passed++;
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_idle: got v=%b b=%b want 0 0", rd_valid, busy);
    else passed++;
    do_arm();
    foreach (inp[i]) feed(inp[i]);
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== inp[i])
        $display("FAIL midrst_read%0d: got v=%b data=%0d want 1 %0d", i, rd_valid, rd_data, inp[i]);
      else passed++;
    end
    rd_req = 1'b0;
  endtask

  task automatic test_pretrig;
    threshold = 8'd20; post_len = 2;
    do_arm();
    for (int v = 0; v <= 40; v++) feed(v[DW-1:0]);
    checks++;
    if (done !== 1'b1) $display("FAIL pretrig_done: got d=%b want 1", done);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] exp_v;
      logic          exp_done;
      exp_v = DW'(7 + i);
      exp_done = (i < 15);
      rd_req = 1'b1; tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v || done !== exp_done)
        $display("FAIL pretrig_read%0d: got v=%b data=%0d d=%b want 1 %0d %b", i, rd_valid, rd_data, done, exp_v, exp_done);
      else passed++;
    end
    rd_req = 1'b0;
  endtask

  // Test sequence
  initial begin
    rst = 1'b0; en = 1'b0; arm = 1'b0; rd_req = 1'b0;
    threshold = '0; post_len = '0; mic_signal = '0;
    test_reset();
`ifdef SIGCAPTURE_PRETRIG_EN
    test_pretrig();
`else
    test_basic();
    test_post_zero();
    test_abort();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
